// File: rtl/go_sequencer.sv
// Go/done handshake initiator: a debounced button press launches ROUNDS go pulses, each awaiting done.
// Optional GO_SEQ_SPURIOUS_CHK_EN: done seen in ISSUE or GAP is treated as a protocol error.
module go_sequencer #(
  parameter int unsigned ROUNDS          = 3,
  parameter int unsigned ROUND_W         = 4,
  parameter logic [23:0] TIMEOUT_CYCLES  = 24'd12_000_000,
  parameter logic [15:0] GAP_CYCLES      = 16'd1000,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd600_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               done,
  output logic               go,
  output logic               busy,
  output logic [ROUND_W-1:0] round,
  output logic               complete,
  output logic               error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS);

  logic        btn_meta;
  logic        btn_sync;
  logic        btn_deb;
  logic [19:0] deb_cnt;
  logic        press;

  logic [2:0]         state;
  logic [23:0]        timer;
  logic [15:0]        gap_cnt;
  logic [ROUND_W-1:0] round_inc;
  logic               gap_done;
  logic               timeout_hit;

  assign round_inc   = round + 1'b1;
  assign gap_done    = (GAP_CYCLES == 16'd0) || (gap_cnt == GAP_CYCLES - 16'd1);
  assign timeout_hit = (timer == TIMEOUT_CYCLES - 24'd1);

  // Synchronizer idles at 1 so a reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta <= 1'b1;
      btn_sync <= 1'b1;
    end else begin
      btn_meta <= start_btn;
      btn_sync <= btn_meta;
    end
  end

  // press fires on the cycle the debounced level falls; releases are silent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_deb <= 1'b1;
      deb_cnt <= '0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_sync != btn_deb) begin
        if (deb_cnt == DEBOUNCE_CYCLES - 20'd1) begin
          btn_deb <= btn_sync;
          deb_cnt <= '0;
          press   <= ~btn_sync;
        end else begin
          deb_cnt <= deb_cnt + 20'd1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // NOTE: state and outputs update with non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      gap_cnt  <= '0;
      go       <= 1'b0;
      busy     <= 1'b0;
      round    <= '0;
      complete <= 1'b0;
      error    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (press) begin
            state    <= S_ISSUE;
            go       <= 1'b1;
            busy     <= 1'b1;
            round    <= '0;
            complete <= 1'b0;
          end
        end
        S_ISSUE: begin
          go    <= 1'b0;
          timer <= '0;
          state <= S_WAIT;
`ifdef GO_SEQ_SPURIOUS_CHK_EN
          if (done) begin
            state <= S_ERROR;
            busy  <= 1'b0;
            error <= 1'b1;
          end
`endif
        end
        S_WAIT: begin
          timer <= timer + 24'd1;
          // done takes priority over a timeout landing on the same cycle.
          if (done) begin
            round <= round_inc;
            if (round_inc == LAST_ROUND) begin
              state    <= S_IDLE;
              busy     <= 1'b0;
              complete <= 1'b1;
            end else begin
              state   <= S_GAP;
              gap_cnt <= '0;
            end
          end else if (timeout_hit) begin
            state <= S_ERROR;
            busy  <= 1'b0;
            error <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_done) begin
            state <= S_ISSUE;
            go    <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
`ifdef GO_SEQ_SPURIOUS_CHK_EN
          if (done) begin
            state <= S_ERROR;
            go    <= 1'b0;
            busy  <= 1'b0;
            error <= 1'b1;
          end
`endif
        end
        S_ERROR: begin
          if (press) begin
            state <= S_IDLE;
            error <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          go    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_go_sequencer.sv
// Bench for go_sequencer: table of runs with a go-timing scoreboard plus bounce, reset and ack sequences.
module tb_go_sequencer;

  localparam int ROUND_W = 4;
  localparam int GAP     = 2;
  localparam int TMO     = 20;

  logic               clk = 1'b0;
  logic               rst;
  logic               start_btn;
  logic               done = 1'b0;
  logic               go;
  logic               busy;
  logic [ROUND_W-1:0] round;
  logic               complete;
  logic               error;

  go_sequencer #(
    .ROUNDS(3), .ROUND_W(ROUND_W), .TIMEOUT_CYCLES(24'd20),
    .GAP_CYCLES(16'd2), .DEBOUNCE_CYCLES(20'd4)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .done(done),
    .go(go), .busy(busy), .round(round), .complete(complete), .error(error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard entry: kind 0 = first go of a run (val = press cycle), kind 1 = spacing to previous go.
  typedef struct { int kind; int val; } sb_t;
  sb_t sb[$];

  int lat = 0;
  bit spur_armed = 0;
  int done_cnt = 0;
  int spur_cnt = 0;
  int gos = 0;
  int last_go = 0;
  int err_rise = 0;
  bit go_prev = 0;
  bit err_prev = 0;
  bit busy_seen = 0;

  // Worker model and output monitor, both away from the active edge.
  always @(negedge clk) begin
    sb_t e;
    done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) done = 1'b1;
    end
    if (spur_cnt > 0) begin
      spur_cnt--;
      if (spur_cnt == 0) done = 1'b1;
    end
    if (busy) busy_seen = 1;
    if (error && !err_prev) err_rise = cyc;
    if (go) begin
      check("go_not_back_to_back", int'(go_prev), 0);
      if (sb.size() == 0) begin
        check("go_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        // Press reaches the FSM after 2 sync + DEBOUNCE_CYCLES + event/state registers.
        if (e.kind == 0) check("go_first_latency_ok", int'(cyc >= e.val + 6 && cyc <= e.val + 8), 1);
        else             check("go_spacing", cyc - last_go, e.val);
      end
      gos++;
      last_go = cyc;
      if (lat > 0) done_cnt = lat;
      if (spur_armed) begin
        spur_cnt   = 6;   // lands in the first GAP cycle when lat = 5
        spur_armed = 0;
      end
    end
    go_prev  = go;
    err_prev = error;
  end

  typedef struct {
    int lat;
    bit spur;
    int exp_gos;
    int exp_round;
    bit exp_complete;
    bit exp_error;
  } vec_t;
  vec_t vec[5];

  task automatic press_hold(input int n);
    start_btn = 1'b0;
    repeat (n) @(negedge clk);
    start_btn = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check({name, "_timeout"}, 0, 1);
    repeat (10) @(negedge clk);
  endtask

  task automatic ack_error();
    int g0;
    g0 = gos;
    busy_seen = 0;
    press_hold(15);
    repeat (20) @(negedge clk);
    check("ack_error_cleared", int'(error), 0);
    check("ack_no_go", gos, g0);
    check("ack_not_busy", int'(busy_seen), 0);
  endtask

  task automatic run_case(input vec_t v, input int idx);
    @(negedge clk);
    lat = v.lat;
    spur_armed = v.spur;
    sb.push_back('{0, cyc});
    for (int r = 1; r < v.exp_gos; r++) sb.push_back('{1, v.lat + 1 + GAP});
    press_hold(15);
    wait_idle($sformatf("run%0d", idx));
    check($sformatf("run%0d_gos_drained", idx), sb.size(), 0);
    check($sformatf("run%0d_round", idx), int'(round), v.exp_round);
    check($sformatf("run%0d_complete", idx), int'(complete), int'(v.exp_complete));
    check($sformatf("run%0d_error", idx), int'(error), int'(v.exp_error));
    check($sformatf("run%0d_busy", idx), int'(busy), 0);
    if (v.exp_error) begin
      check($sformatf("run%0d_error_latency", idx), err_rise - last_go, v.spur ? 7 : TMO + 1);
      ack_error();
    end
    sb.delete();
    spur_armed = 0;
  endtask

  initial begin
    int g0;
    vec[0] = '{5,  0, 3, 3, 1, 0};   // normal run
    vec[1] = '{1,  0, 3, 3, 1, 0};   // done in the first WAIT cycle
    vec[2] = '{20, 0, 3, 3, 1, 0};   // done on the timeout cycle: done wins
    vec[3] = '{0,  0, 1, 0, 0, 1};   // no done: timeout
`ifdef GO_SEQ_SPURIOUS_CHK_EN
    vec[4] = '{5,  1, 1, 1, 0, 1};   // spurious done in GAP is an error
`else
    vec[4] = '{5,  1, 3, 3, 1, 0};   // spurious done in GAP is ignored
`endif

    rst = 1'b1;
    start_btn = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_go", int'(go), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_round", int'(round), 0);
    check("rst_complete", int'(complete), 0);
    check("rst_error", int'(error), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) run_case(vec[i], i);

    // Bounce: no level survives 4 stable cycles, so nothing may start.
    g0 = gos;
    busy_seen = 0;
    for (int i = 0; i < 5; i++) begin
      start_btn = 1'b0;
      repeat (2) @(negedge clk);
      start_btn = 1'b1;
      repeat (2) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check("bounce_no_go", gos, g0);
    check("bounce_not_busy", int'(busy_seen), 0);

    // Reset during round 2's WAIT, then a fresh run.
    @(negedge clk);
    lat = 5;
    g0 = gos;
    sb.push_back('{0, cyc});
    sb.push_back('{1, 5 + 1 + GAP});
    press_hold(15);
    for (int i = 0; i < 200 && gos < g0 + 2; i++) @(negedge clk);
    check("midrun_second_go_seen", gos, g0 + 2);
    repeat (2) @(negedge clk);
    check("midrun_round_before_rst", int'(round), 1);
    check("midrun_busy_before_rst", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_go", int'(go), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_round", int'(round), 0);
    check("async_rst_complete", int'(complete), 0);
    check("async_rst_error", int'(error), 0);
    sb.delete();
    done_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    run_case(vec[0], 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
